sprite_scan: RTL and testbench

Per-scanline sprite evaluator feeding the sprite file. On each `start` it walks OAM in ascending index order and selects sprites whose vertical span covers the requested row. For each hit it fetches that sprite's 8-pixel pattern row and pushes one `sprite_reg_t` into the sprite file over a valid/ack handshake, stopping after `SPRITES` hits. It runs during horizontal blank, one line ahead of pixel output.

---
 rtl/sprite_scan_pkg.sv | 31 +++
 rtl/sprite_row_select.sv | 29 ++
 rtl/sprite_scan.sv | 156 +++++++++++++++
 tb/tb_sprite_scan.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_scan_pkg.sv
// Shared OAM entry / sprite register types and line-limit defaults for the sprite scanner.
`ifndef MAX_SPRITES_PER_LINE
`define MAX_SPRITES_PER_LINE 4
`endif
`ifndef OAM_ENTRY_W
`define OAM_ENTRY_W 36
`endif

package sprite_defines;
  localparam int MAX_SPRITES = `MAX_SPRITES_PER_LINE;
  localparam int OAM_ENTRY_W = `OAM_ENTRY_W;

  // Field order is MSB first; "prio" stands in for the reserved word priority.
  typedef struct packed {
    logic [7:0] y;
    logic [8:0] x;
    logic [9:0] tile;
    logic [3:0] palette;
    logic [1:0] prio;
    logic       hflip;
    logic       vflip;
    logic       tall;
  } oam_entry_t;

  typedef struct packed {
    logic [8:0]  x;
    logic [3:0]  palette;
    logic [1:0]  prio;
    logic [31:0] pattern;
  } sprite_reg_t;
endpackage

// File: rtl/sprite_row_select.sv
// Combinational hit test, pattern-line selection (with vflip) and hflip nibble reversal.
module sprite_row_select
  import sprite_defines::*;
(
  input  logic [7:0]  row,
  input  oam_entry_t  entry,
  input  logic        hflip,
  input  logic [31:0] pattern_in,
  output logic        hit,
  output logic [3:0]  line,
  output logic [31:0] pattern_out
);
  logic [7:0] diff;
  logic [7:0] height;
  logic [3:0] flip_line;

  always_comb begin
    diff   = row - entry.y;
    height = entry.tall ? 8'd16 : 8'd8;
    hit    = diff < height;
    // Only meaningful on a hit, where diff < height fits in four bits.
    flip_line = (entry.tall ? 4'd15 : 4'd7) - diff[3:0];
    line      = entry.vflip ? flip_line : diff[3:0];
    pattern_out = pattern_in;
    for (int i = 0; i < 8; i++) begin
      pattern_out[4*i +: 4] = hflip ? pattern_in[4*(7-i) +: 4] : pattern_in[4*i +: 4];
    end
  end
endmodule

// File: rtl/sprite_scan.sv
// Per-scanline OAM walker feeding the sprite file over valid/ack.
// Define SPRITE_OVERFLOW_EN to keep scanning after the line fills and flag a further hit.
module sprite_scan
  import sprite_defines::*;
#(
  parameter int OAM_ENTRIES = 64,
  parameter int SPRITES     = MAX_SPRITES
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [7:0]                     row,
  output logic [$clog2(OAM_ENTRIES)-1:0] oam_addr,
  input  logic [OAM_ENTRY_W-1:0]         oam_data,
  output logic [13:0]                    pattern_addr,
  input  logic [31:0]                    pattern_data,
  output sprite_reg_t                    out,
  output logic                           out_valid,
  input  logic                           out_ack,
  output logic                           clear,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);
  localparam int IDX_W = $clog2(OAM_ENTRIES);
  localparam int CNT_W = $clog2(SPRITES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OAM_ENTRIES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SPRITES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPRITES - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] PAT   = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic [7:0]       row_q;
  oam_entry_t       ent;
  logic [8:0]       x_q;
  logic [3:0]       pal_q;
  logic [1:0]       prio_q;
  logic             hflip_q;
  logic             hit;
  logic [3:0]       line;
  logic [31:0]      pat_row;
  logic             stop_after_emit;

  assign ent  = oam_entry_t'(oam_data);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

`ifdef SPRITE_OVERFLOW_EN
  assign stop_after_emit = 1'b0;
`else
  assign stop_after_emit = (count == CNT_LAST);
  assign overflow        = 1'b0;
`endif

  sprite_row_select u_row_select (
    .row         (row_q),
    .entry       (ent),
    .hflip       (hflip_q),
    .pattern_in  (pattern_data),
    .hit         (hit),
    .line        (line),
    .pattern_out (pat_row)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      count        <= '0;
      row_q        <= '0;
      oam_addr     <= '0;
      pattern_addr <= '0;
      out          <= '0;
      out_valid    <= 1'b0;
      clear        <= 1'b0;
      x_q          <= '0;
      pal_q        <= '0;
      prio_q       <= '0;
      hflip_q      <= 1'b0;
`ifdef SPRITE_OVERFLOW_EN
      overflow     <= 1'b0;
`endif
    end else begin
      clear <= 1'b0;
      if (start) begin
        // Restart wins over everything, including a sprite waiting for ack.
        state     <= FETCH;
        idx       <= '0;
        count     <= '0;
        row_q     <= row;
        oam_addr  <= '0;
        out_valid <= 1'b0;
        clear     <= 1'b1;
`ifdef SPRITE_OVERFLOW_EN
        overflow  <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE:  state <= IDLE;
          FETCH: state <= CHECK;
          CHECK: begin
            if (hit && count != CNT_MAX) begin
              x_q          <= ent.x;
              pal_q        <= ent.palette;
              prio_q       <= ent.prio;
              hflip_q      <= ent.hflip;
              pattern_addr <= {ent.tile, line};
              state        <= PAT;
            end
`ifdef SPRITE_OVERFLOW_EN
            else if (hit) begin
              overflow <= 1'b1;
              state    <= DONE;
            end
`endif
            else if (idx == IDX_LAST) begin
              state <= DONE;
            end else begin
              idx      <= idx + 1'b1;
              oam_addr <= idx + 1'b1;
              state    <= FETCH;
            end
          end
          PAT: begin
            out       <= '{x: x_q, palette: pal_q, prio: prio_q, pattern: pat_row};
            out_valid <= 1'b1;
            state     <= EMIT;
          end
          EMIT: begin
            if (out_ack) begin
              out_valid <= 1'b0;
              count     <= count + 1'b1;
              if (idx == IDX_LAST || stop_after_emit) begin
                state <= DONE;
              end else begin
                idx      <= idx + 1'b1;
                oam_addr <= idx + 1'b1;
                state    <= FETCH;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sprite_scan.sv
// Directed bench for sprite_scan: OAM and pattern memories modelled as reads of the registered addresses.
module tb_sprite_scan;
  import sprite_defines::*;

  localparam int SP = MAX_SPRITES;

  logic              clock;
  logic              reset;
  logic              start;
  logic [7:0]        row;
  logic [5:0]        oam_addr;
  logic [OAM_ENTRY_W-1:0] oam_data;
  logic [13:0]       pattern_addr;
  logic [31:0]       pattern_data;
  sprite_reg_t       out;
  logic              out_valid;
  logic              out_ack;
  logic              clear;
  logic              busy;
  logic              done;
  logic              overflow;

  oam_entry_t  oam_mem [64];
  logic        pat_ovr_en;
  logic [31:0] pat_ovr;

  int checks;
  int errors;
  int cyc;
  int done_cyc;
  int emit_cnt;
  int unstable;
  int          emit_cyc [16];
  sprite_reg_t emit_out [16];

  sprite_scan #(.OAM_ENTRIES(64), .SPRITES(SP)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .row          (row),
    .oam_addr     (oam_addr),
    .oam_data     (oam_data),
    .pattern_addr (pattern_addr),
    .pattern_data (pattern_data),
    .out          (out),
    .out_valid    (out_valid),
    .out_ack      (out_ack),
    .clear        (clear),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  assign oam_data     = oam_mem[oam_addr];
  assign pattern_data = pat_ovr_en ? pat_ovr : {2'b00, pattern_addr, 2'b00, pattern_addr};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic oam_entry_t mk(input logic [7:0] y, input logic [8:0] x,
                                    input logic [9:0] tile, input logic [3:0] pal,
                                    input logic [1:0] pr, input logic hf,
                                    input logic vf, input logic tl);
    oam_entry_t e;
    e.y = y; e.x = x; e.tile = tile; e.palette = pal;
    e.prio = pr; e.hflip = hf; e.vflip = vf; e.tall = tl;
    return e;
  endfunction

  function automatic sprite_reg_t spr(input logic [8:0] x, input logic [3:0] pal,
                                      input logic [1:0] pr, input logic [31:0] pat);
    sprite_reg_t s;
    s.x = x; s.palette = pal; s.prio = pr; s.pattern = pat;
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic all_miss();
    for (int i = 0; i < 64; i++) oam_mem[i] = mk(8'd200, 9'd0, 10'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Pulses start now (cycle 0), then acks each sprite ack_dly cycles after out_valid rises.
  task automatic run_scan(input string tag, input logic [7:0] r, input int ack_dly, input int max_cyc);
    int wait_cnt;
    sprite_reg_t held;
    wait_cnt = 0; held = '0;
    emit_cnt = 0; done_cyc = -1; unstable = 0; cyc = 0;
    start = 1'b1; row = r; out_ack = 1'b0;
    tick();
    start = 1'b0;
    check({tag, "_busy_c1"}, 64'(busy), 64'd1);
    check({tag, "_clear_c1"}, 64'(clear), 64'd1);
    check({tag, "_oam_addr_c1"}, 64'(oam_addr), 64'd0);
    check({tag, "_valid_c1"}, 64'(out_valid), 64'd0);
    check({tag, "_ovf_c1"}, 64'(overflow), 64'd0);
    while (done_cyc < 0 && cyc < max_cyc) begin
      if (out_valid) begin
        if (wait_cnt == 0) held = out;
        else if (out !== held) unstable++;
        out_ack = (wait_cnt >= ack_dly);
        if (out_ack) begin
          if (emit_cnt < 16) begin
            emit_cyc[emit_cnt] = cyc;
            emit_out[emit_cnt] = out;
          end
          emit_cnt++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        out_ack  = 1'b0;
        wait_cnt = 0;
      end
      if (done) done_cyc = cyc;
      tick();
    end
    out_ack = 1'b0;
    check({tag, "_no_timeout"}, 64'(done_cyc >= 0), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    reset = 1'b1; start = 1'b0; row = 8'd0; out_ack = 1'b0;
    pat_ovr_en = 1'b0; pat_ovr = 32'd0;
    all_miss();

    // Power-on reset values
    @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_clear_done", 64'({clear, done, overflow}), 64'd0);
    check("rst_addrs", 64'({oam_addr, pattern_addr}), 64'd0);
    reset = 1'b0;
    tick();
    tick();

    // Row 10: entry 3 short at y=5 (line 5), entry 7 tall at y=0 (line 10)
    all_miss();
    oam_mem[3] = mk(8'd5, 9'd3, 10'h003, 4'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    oam_mem[7] = mk(8'd0, 9'd7, 10'h007, 4'd2, 2'd2, 1'b0, 1'b0, 1'b1);
    run_scan("two_hits", 8'd10, 0, 400);
    check("two_hits_cnt", 64'(emit_cnt), 64'd2);
    check("two_hits_c0", 64'(emit_cyc[0]), 64'd10);
    check("two_hits_s0", 64'(emit_out[0]), 64'(spr(9'd3, 4'd1, 2'd1, 32'h0035_0035)));
    check("two_hits_c1", 64'(emit_cyc[1]), 64'd20);
    check("two_hits_s1", 64'(emit_out[1]), 64'(spr(9'd7, 4'd2, 2'd2, 32'h007A_007A)));
    check("two_hits_done", 64'(done_cyc), 64'd133);

    // Wrapped tall sprite at y=250 with vflip, row 4: diff 10 -> line 5
    all_miss();
    oam_mem[0] = mk(8'd250, 9'h100, 10'h0AB, 4'hF, 2'd3, 1'b0, 1'b1, 1'b1);
    run_scan("wrap_vflip", 8'd4, 0, 400);
    check("wrap_vflip_cnt", 64'(emit_cnt), 64'd1);
    check("wrap_vflip_c0", 64'(emit_cyc[0]), 64'd4);
    check("wrap_vflip_paddr", 64'(pattern_addr), 64'h0AB5);
    check("wrap_vflip_s0", 64'(emit_out[0]), 64'(spr(9'h100, 4'hF, 2'd3, 32'h0AB5_0AB5)));
    check("wrap_vflip_done", 64'(done_cyc), 64'd131);

    // hflip reverses nibble order
    all_miss();
    oam_mem[0] = mk(8'd0, 9'h1FF, 10'h3FF, 4'd5, 2'd2, 1'b1, 1'b0, 1'b0);
    pat_ovr_en = 1'b1; pat_ovr = 32'h7654_3210;
    run_scan("hflip", 8'd0, 0, 400);
    pat_ovr_en = 1'b0;
    check("hflip_cnt", 64'(emit_cnt), 64'd1);
    check("hflip_paddr", 64'(pattern_addr), 64'h3FF0);
    check("hflip_s0", 64'(emit_out[0]), 64'(spr(9'h1FF, 4'd5, 2'd2, 32'h0123_4567)));

    // SP+2 hits with ack delayed 3 cycles: only SP emitted, out held while waiting
    all_miss();
    for (int k = 0; k < SP + 2; k++)
      oam_mem[k] = mk(8'd0, 9'(k), 10'(k), 4'(k), 2'(k), 1'b0, 1'b0, 1'b0);
    run_scan("full", 8'd2, 3, 600);
    check("full_cnt", 64'(emit_cnt), 64'(SP));
    check("full_stable", 64'(unstable), 64'd0);
    check("full_c0", 64'(emit_cyc[0]), 64'd7);
    check("full_clast", 64'(emit_cyc[SP-1]), 64'(7 * SP));
    check("full_slast", 64'(emit_out[SP-1]),
          64'(spr(9'(SP-1), 4'(SP-1), 2'(SP-1), {2'b00, 10'(SP-1), 4'd2, 2'b00, 10'(SP-1), 4'd2})));
`ifdef SPRITE_OVERFLOW_EN
    check("full_done", 64'(done_cyc), 64'(7 * SP + 3));
    check("full_ovf", 64'(overflow), 64'd1);
`else
    check("full_done", 64'(done_cyc), 64'(7 * SP + 1));
    check("full_ovf", 64'(overflow), 64'd0);
`endif

    // start while a sprite waits in EMIT: it is dropped and the scan restarts with the new row
    all_miss();
    oam_mem[0] = mk(8'd0, 9'd0, 10'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    oam_mem[1] = mk(8'd20, 9'd1, 10'd1, 4'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    start = 1'b1; row = 8'd0; out_ack = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("restart_pre_valid", 64'(out_valid), 64'd1);
    check("restart_pre_x", 64'(out.x), 64'd0);
    run_scan("restart", 8'd20, 0, 400);
    check("restart_cnt", 64'(emit_cnt), 64'd1);
    check("restart_c0", 64'(emit_cyc[0]), 64'd6);
    check("restart_s0", 64'(emit_out[0]), 64'(spr(9'd1, 4'd3, 2'd1, 32'h0010_0010)));
    check("restart_done", 64'(done_cyc), 64'd131);

    // Asynchronous reset in the middle of a hit
    all_miss();
    oam_mem[3] = mk(8'd5, 9'd3, 10'h003, 4'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    start = 1'b1; row = 8'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("midrst_pre_busy", 64'(busy), 64'd1);
    check("midrst_pre_paddr", 64'(pattern_addr), 64'h0035);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out", 64'({out, out_valid}), 64'd0);
    check("midrst_addrs", 64'({oam_addr, pattern_addr}), 64'd0);
    check("midrst_flags", 64'({clear, done, overflow}), 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("postrst_idle", 64'({busy, done, out_valid}), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
